frv_mem_bus_model: RTL and testbench
====================================

// Module: frv_mem_bus_model
//
// PURPOSE
// Parametrised, bounded-fairness memory responder for frv_core imem/dmem ports.
// Used in the formal and simulation environments in place of free $anyseq bus inputs.
// Supports up to DEPTH outstanding requests and a backing word store.
// Bounds grant and response stalls to MAX_STALL, so liveness holds by construction.
//
// PARAMETERS
// XLEN      32    data/address width
// DEPTH     2     max outstanding (granted, not yet acked) requests; power of 2, >=1
// MEM_WORDS 1024  backing store size in XLEN words
// BASE_ADDR 0     byte address of word 0
// LATENCY   1     min cycles from grant to mem_recv; >=1
// MAX_STALL 4     max consecutive stall-injected cycles; 0 = stall inputs ignored
//
// PORTS
// g_clk        in   1         clock
// g_resetn     in   1         asynchronous active-low reset
// mem_req      in   1         core request; held until mem_gnt
// mem_wen      in   1         write enable
// mem_strb     in   XLEN/8    byte write strobes
// mem_wdata    in   XLEN      write data
// mem_addr     in   XLEN      byte address
// mem_gnt      out  1         request accepted this cycle (combinational)
// mem_recv     out  1         response valid; held until mem_ack
// mem_ack      in   1         core accepts response
// mem_error    out  1         response is a bus error
// mem_rdata    out  XLEN      response read data
// stall_gnt    in   1         stall-injection request for grant (tie to $anyseq)
// stall_rsp    in   1         stall-injection request for response
// outstanding  out  clog2(DEPTH+1)  number of in-flight entries
//
// BEHAVIOUR
// - Reset (async, g_resetn=0): FIFO emptied, stall counters cleared.
//   mem_recv=0, mem_error=0, mem_rdata=0, outstanding=0, mem_gnt=0.
//   The backing store is not reset. Reset mid-transaction discards all in-flight entries.
// - Grant: mem_gnt = mem_req & !full & (!stall_gnt | gstall==MAX_STALL).
//   Full blocks grant even if a pop occurs in the same cycle; there is no bypass.
// - gstall counter:
//   +1 on each cycle where mem_req & !full & !mem_gnt.
//   Cleared on mem_gnt or !mem_req. Saturates at MAX_STALL.
// - On accept (mem_req & mem_gnt): one entry {rdata, error, countdown=LATENCY} is pushed.
//   Word index = (mem_addr-BASE_ADDR)>>2.
//   error = mem_addr[1:0]!=0 | index>=MEM_WORDS.
//   Read: rdata = store[index] sampled at accept; 0 if error.
//   Write: bytes with mem_strb set are committed at the accept clock edge. No write on error.
//   Write responses return rdata=0.
// - Each entry's countdown decrements every cycle and saturates at 0.
// - Response:
//   Head is eligible when its countdown==0.
//   mem_recv rises when the head is eligible & (!stall_rsp | rstall==MAX_STALL).
//   Once high, mem_recv, mem_rdata and mem_error stay stable until mem_recv & mem_ack.
//   stall_rsp is ignored while mem_recv=1.
// - rstall counter: +1 per cycle where the head is eligible and recv is withheld.
//   Cleared when mem_recv rises.
// - Pop on mem_recv & mem_ack. If the next head is already eligible, mem_recv may stay high
//   the following cycle with new data. Earliest recv is the cycle after grant.
//   mem_rdata/mem_error return to 0 when mem_recv=0.
// - Push and pop in the same cycle (not full): outstanding is unchanged.
// - FIFO pointers wrap modulo DEPTH.
// - mem_ack while mem_recv=0 is ignored.
// - outstanding is registered and equals the FIFO occupancy.
//
// TESTING
// 1. Write 0xDEADBEEF to 0x10, strb=4'hF, then read 0x10, no stalls, LATENCY=1 ->
//    gnt same cycle; recv 1 cycle later; rdata=0xDEADBEEF, error=0.
// 2. strb=4'b0010 write of 0x0000AB00 over 0xDEADBEEF, then read ->
//    rdata=0xDEADABEF.
// 3. Read 0x13 (misaligned) and read MEM_WORDS*4 (out of range) ->
//    error=1, rdata=0; store unchanged.
// 4. stall_gnt held 1, req held, MAX_STALL=4 ->
//    gnt forced on 5th cycle; stall_rsp held 1 -> recv forced after 4 stalled cycles.
// 5. DEPTH=2, three back-to-back reads, ack withheld ->
//    third gnt blocked (outstanding=2); ack -> outstanding=1, third gnt next cycle;
//    responses returned in order.
// 6. Assert g_resetn=0 with 2 in flight and recv high ->
//    recv, outstanding, rdata go 0 immediately; no stale response after release.

Source files
------------

// File: rtl/frv_mem_bus_model_if.sv
// ---------------------------------------------------------------------------
// frv_mem_bus_model_if
// Request/response bus between an frv_core memory port and a memory model.
//
// Signals
//   mem_req   core request, held until mem_gnt
//   mem_wen   write enable
//   mem_strb  byte write strobes (XLEN/8)
//   mem_wdata write data
//   mem_addr  byte address
//   mem_gnt   request accepted this cycle
//   mem_recv  response valid, held until mem_ack
//   mem_ack   core accepts the response
//   mem_error response is a bus error
//   mem_rdata response read data
//
// Modports: master = core side, slave = memory side.
// ---------------------------------------------------------------------------
interface frv_mem_bus_model_if #(
    parameter int XLEN = 32
);
    logic                mem_req;
    logic                mem_wen;
    logic [XLEN/8-1:0]   mem_strb;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN-1:0]     mem_addr;
    logic                mem_gnt;
    logic                mem_recv;
    logic                mem_ack;
    logic                mem_error;
    logic [XLEN-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );
endinterface

// File: rtl/frv_mem_bus_model.sv
// ---------------------------------------------------------------------------
// frv_mem_bus_model
// Bounded-fairness memory responder for the frv_core imem/dmem ports.
// Accepts up to DEPTH outstanding requests into an in-order FIFO, serves them
// from a backing word store, and lets the environment inject grant/response
// stalls that are capped at MAX_STALL consecutive cycles.
//
// Ports
//   g_clk        clock
//   g_resetn     asynchronous active-low reset
//   bus          memory bus (slave modport)
//   stall_gnt    stall-injection request for grant
//   stall_rsp    stall-injection request for response
//   outstanding  number of in-flight (granted, not yet acked) entries
// ---------------------------------------------------------------------------
module frv_mem_bus_model #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 2,
    parameter int              MEM_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter int              LATENCY   = 1,
    parameter int              MAX_STALL = 4
) (
    input  logic                         g_clk,
    input  logic                         g_resetn,
    frv_mem_bus_model_if.slave           bus,
    input  logic                         stall_gnt,
    input  logic                         stall_rsp,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int SW = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;
    localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int NB = XLEN / 8;

    localparam logic [SW-1:0]   STALL_MAX  = SW'(MAX_STALL);
    localparam logic [OW-1:0]   FULL_COUNT = OW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [XLEN-1:0] MW         = XLEN'(MEM_WORDS);
    // An entry only becomes visible at the head one cycle after its accept
    // edge, so it is loaded with LATENCY-1 to give recv exactly LATENCY
    // cycles after grant at the earliest.
    localparam logic [CW-1:0]   CD_INIT    = CW'(LATENCY - 1);

    typedef enum logic {
        RSP_IDLE,
        RSP_HOLD
    } rsp_state_t;

    // Backing store: never reset, survives g_resetn.
    logic [XLEN-1:0] store [MEM_WORDS];

    // FIFO of pending responses
    logic [XLEN-1:0] rdata_reg [DEPTH];
    logic            err_reg   [DEPTH];
    logic [CW-1:0]   cd_reg    [DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [OW-1:0]   count_reg;

    logic [SW-1:0]   gstall_reg, rstall_reg;
    rsp_state_t      rsp_state_reg, rsp_state_next;

    logic            full, empty, gnt, push, pop, recv, head_elig;
    logic [XLEN-1:0] word;
    logic            acc_err;
    logic [IW-1:0]   idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Address decode
    assign word    = (bus.mem_addr - BASE_ADDR) >> 2;
    assign acc_err = (bus.mem_addr[1:0] != 2'b00) || (word >= MW);
    assign idx     = word[IW-1:0];

    // Grant: full blocks even if the head pops this cycle (no bypass).
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    assign gnt   = g_resetn & bus.mem_req & ~full &
                   (~stall_gnt | (gstall_reg == STALL_MAX));
    assign push  = gnt;

    assign head_elig = ~empty && (cd_reg[rd_ptr_reg] == '0);

    // Response FSM: HOLD freezes recv (and the head) until the core acks,
    // which is also what makes stall_rsp irrelevant once recv is high.
    always_comb begin
        rsp_state_next = rsp_state_reg;
        recv           = 1'b0;
        case (rsp_state_reg)
            RSP_IDLE: begin
                if (head_elig && (!stall_rsp || rstall_reg == STALL_MAX))
                    recv = 1'b1;
                if (recv && !bus.mem_ack)
                    rsp_state_next = RSP_HOLD;
            end
            RSP_HOLD: begin
                recv = 1'b1;
                if (bus.mem_ack)
                    rsp_state_next = RSP_IDLE;
            end
            default: rsp_state_next = RSP_IDLE;
        endcase
    end

    assign pop           = recv & bus.mem_ack;
    assign bus.mem_gnt   = gnt;
    assign bus.mem_recv  = recv;
    assign bus.mem_rdata = recv ? rdata_reg[rd_ptr_reg] : '0;
    assign bus.mem_error = recv ? err_reg[rd_ptr_reg] : 1'b0;
    assign outstanding   = count_reg;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            gstall_reg    <= '0;
            rstall_reg    <= '0;
            rsp_state_reg <= RSP_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                rdata_reg[i] <= '0;
                err_reg[i]   <= 1'b0;
                cd_reg[i]    <= '0;
            end
        end else begin
            rsp_state_reg <= rsp_state_next;

            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);

            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            // Grant stall counter only advances while the request is
            // actually being held back by injection (not by a full FIFO).
            if (!bus.mem_req || gnt)
                gstall_reg <= '0;
            else if (!full && gstall_reg != STALL_MAX)
                gstall_reg <= gstall_reg + 1'b1;

            if (recv)
                rstall_reg <= '0;
            else if (head_elig && rstall_reg != STALL_MAX)
                rstall_reg <= rstall_reg + 1'b1;

            for (int i = 0; i < DEPTH; i++) begin
                if (push && wr_ptr_reg == PW'(i)) begin
                    // Read data sampled at the accept edge; writes and
                    // errors answer with zero.
                    rdata_reg[i] <= (bus.mem_wen || acc_err) ? '0 : store[idx];
                    err_reg[i]   <= acc_err;
                    cd_reg[i]    <= CD_INIT;
                end else if (cd_reg[i] != '0) begin
                    cd_reg[i] <= cd_reg[i] - 1'b1;
                end
            end
        end
    end

    // Byte-strobed write committed at the accept edge.
    always_ff @(posedge g_clk) begin
        if (push && bus.mem_wen && !acc_err) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.mem_strb[b])
                    store[idx][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_frv_mem_bus_model.sv
// ---------------------------------------------------------------------------
// tb_frv_mem_bus_model
// Self-checking bench for frv_mem_bus_model (XLEN=32, DEPTH=2, LATENCY=1,
// MAX_STALL=4, MEM_WORDS=1024). Expected responses are queued when a request
// is granted and compared in order when the model returns them.
// ---------------------------------------------------------------------------
module tb_frv_mem_bus_model;

    logic       g_clk     = 1'b0;
    logic       g_resetn  = 1'b1;
    logic       stall_gnt = 1'b0;
    logic       stall_rsp = 1'b0;
    logic [1:0] outstanding;

    frv_mem_bus_model_if #(.XLEN(32)) bus ();

    frv_mem_bus_model #(
        .XLEN      (32),
        .DEPTH     (2),
        .MEM_WORDS (1024),
        .BASE_ADDR (32'h0),
        .LATENCY   (1),
        .MAX_STALL (4)
    ) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .bus         (bus),
        .stall_gnt   (stall_gnt),
        .stall_rsp   (stall_rsp),
        .outstanding (outstanding)
    );

    always #5 g_clk = ~g_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_rdata;
    logic        hold_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge g_clk) begin
        if (!g_resetn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("rsp_hold_recv",  bus.mem_recv,  1);
                check("rsp_hold_rdata", bus.mem_rdata, hold_rdata);
                check("rsp_hold_err",   bus.mem_error, hold_err);
                hold_pend = 1'b0;
            end
            if (bus.mem_recv) begin
                if (bus.mem_ack) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rsp_unexpected: got rdata=%h err=%0d want no response",
                                 bus.mem_rdata, bus.mem_error);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("rsp_rdata", bus.mem_rdata, mon_e.rdata);
                        check("rsp_err",   bus.mem_error, mon_e.err);
                        $display("rsp rdata=%h err=%0d", bus.mem_rdata, bus.mem_error);
                    end
                end else begin
                    hold_pend  = 1'b1;
                    hold_rdata = bus.mem_rdata;
                    hold_err   = bus.mem_error;
                end
            end else begin
                check("idle_rdata", bus.mem_rdata, 0);
                check("idle_err",   bus.mem_error, 0);
            end
        end
    end

    task automatic push_exp(input logic [31:0] rd, input logic er);
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        sb_q.push_back(e);
    endtask

    // Issue one request; called just after a posedge, returns just after the
    // posedge that accepted it. waited = cycles without grant.
    task automatic do_req(input logic wen, input logic [3:0] strb, input logic [31:0] wdata,
                          input logic [31:0] addr, input logic [31:0] exp_rd,
                          input logic exp_err, output int waited);
        bit got;
        got           = 0;
        waited        = 0;
        bus.mem_req   = 1'b1;
        bus.mem_wen   = wen;
        bus.mem_strb  = strb;
        bus.mem_wdata = wdata;
        bus.mem_addr  = addr;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge g_clk);
            if (bus.mem_gnt) begin
                got = 1;
                push_exp(exp_rd, exp_err);
            end else begin
                waited++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout: got no grant want grant for addr %h", addr);
        end
        @(posedge g_clk);
        #1;
        bus.mem_req = 1'b0;
        bus.mem_wen = 1'b0;
        $display("req addr=%h wen=%0d strb=%h wdata=%h wait=%0d", addr, wen, strb, wdata, waited);
    endtask

    task automatic wait_recv(output int stalled);
        bit got;
        got     = 0;
        stalled = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge g_clk);
            if (bus.mem_recv) got = 1;
            else              stalled++;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL recv_timeout: got no recv want recv");
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 60; c++) begin
            if (sb_q.size() == 0 && !bus.mem_recv) break;
            @(negedge g_clk);
        end
        check("drain_queue", sb_q.size(), 0);
        @(posedge g_clk);
        #1;
    endtask

    vec_t vecs[15];
    int   w, s;

    initial begin
        vecs[0]  = '{1'b1, 4'hF, 32'hDEADBEEF, 32'h0000_0010, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0010, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 4'h2, 32'h0000AB00, 32'h0000_0010, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0010, 32'hDEADABEF, 1'b0};
        vecs[4]  = '{1'b1, 4'hF, 32'h11223344, 32'h0000_0000, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0013, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,        32'h0000_1000, 32'h0,        1'b1};
        vecs[7]  = '{1'b1, 4'hF, 32'h12345678, 32'h0000_0013, 32'h0,        1'b1};
        vecs[8]  = '{1'b1, 4'hF, 32'hCAFEF00D, 32'h0000_1000, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,        32'h0000_0010, 32'hDEADABEF, 1'b0};
        vecs[10] = '{1'b0, 4'h0, 32'h0,        32'h0000_0000, 32'h11223344, 1'b0};
        vecs[11] = '{1'b1, 4'hF, 32'h01020304, 32'h0000_0FFC, 32'h0,        1'b0};
        vecs[12] = '{1'b1, 4'h9, 32'hAABBCCDD, 32'h0000_0FFC, 32'h0,        1'b0};
        vecs[13] = '{1'b0, 4'h0, 32'h0,        32'h0000_0FFC, 32'hAA0203DD, 1'b0};
        vecs[14] = '{1'b0, 4'h0, 32'h0,        32'hFFFF_FFFC, 32'h0,        1'b1};

        bus.mem_req   = 1'b1;
        bus.mem_wen   = 1'b0;
        bus.mem_strb  = 4'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = 32'h10;
        bus.mem_ack   = 1'b1;

        // Reset state (request held to show grant is gated)
        #1 g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        check("reset_gnt",   bus.mem_gnt,   0);
        check("reset_recv",  bus.mem_recv,  0);
        check("reset_out",   outstanding,   0);
        check("reset_rdata", bus.mem_rdata, 0);
        check("reset_err",   bus.mem_error, 0);
        bus.mem_req = 1'b0;
        #2 g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        // Table-driven single transactions, no stalls
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].wen, vecs[i].strb, vecs[i].wdata, vecs[i].addr,
                   vecs[i].exp_rdata, vecs[i].exp_err, w);
            check("tbl_gnt_wait", w, 0);
            drain();
        end

        // Minimum latency: recv the cycle after grant, then held while ack low
        bus.mem_ack = 1'b0;
        do_req(1'b0, 4'h0, 32'h0, 32'h10, 32'hDEADABEF, 1'b0, w);
        wait_recv(s);
        check("lat_recv_delay", s, 0);
        @(posedge g_clk);
        #1;
        bus.mem_ack = 1'b1;
        drain();

        // Stall bounds: grant forced after 4 stalled cycles, recv likewise
        stall_gnt   = 1'b1;
        stall_rsp   = 1'b1;
        bus.mem_ack = 1'b0;
        do_req(1'b0, 4'h0, 32'h0, 32'h0, 32'h11223344, 1'b0, w);
        check("gnt_stall_cycles", w, 4);
        wait_recv(s);
        check("rsp_stall_cycles", s, 4);
        repeat (2) begin
            @(posedge g_clk);
            #1;
        end
        bus.mem_ack = 1'b1;
        drain();
        stall_gnt = 1'b0;
        stall_rsp = 1'b0;

        // Back-to-back reads with ack withheld: third blocked while full
        bus.mem_ack  = 1'b0;
        bus.mem_req  = 1'b1;
        bus.mem_wen  = 1'b0;
        bus.mem_addr = 32'h10;
        @(negedge g_clk);
        check("b2b_gnt0", bus.mem_gnt, 1);
        push_exp(32'hDEADABEF, 1'b0);
        @(posedge g_clk);
        #1 bus.mem_addr = 32'h0;
        @(negedge g_clk);
        check("b2b_gnt1", bus.mem_gnt, 1);
        push_exp(32'h11223344, 1'b0);
        @(posedge g_clk);
        #1 bus.mem_addr = 32'hFFC;
        @(negedge g_clk);
        check("b2b_gnt2_full", bus.mem_gnt, 0);
        check("b2b_out_full",  outstanding, 2);
        @(posedge g_clk);
        #1;
        @(negedge g_clk);
        check("b2b_gnt2_still", bus.mem_gnt, 0);
        @(posedge g_clk);
        #1 bus.mem_ack = 1'b1;
        @(negedge g_clk);
        check("b2b_gnt_pop_cycle", bus.mem_gnt, 0);
        @(posedge g_clk);
        #1;
        @(negedge g_clk);
        check("b2b_out_after_ack", outstanding, 1);
        check("b2b_gnt2_after",    bus.mem_gnt, 1);
        push_exp(32'hAA0203DD, 1'b0);
        @(posedge g_clk);
        #1 bus.mem_req = 1'b0;
        drain();
        check("b2b_out_empty", outstanding, 0);

        // Reset with two in flight and recv high
        bus.mem_ack = 1'b0;
        do_req(1'b0, 4'h0, 32'h0, 32'h10, 32'hDEADABEF, 1'b0, w);
        do_req(1'b0, 4'h0, 32'h0, 32'h0,  32'h11223344, 1'b0, w);
        @(negedge g_clk);
        check("rst_pre_recv", bus.mem_recv, 1);
        check("rst_pre_out",  outstanding,  2);
        #2 g_resetn = 1'b0;
        #1;
        check("rst_recv",  bus.mem_recv,  0);
        check("rst_out",   outstanding,   0);
        check("rst_rdata", bus.mem_rdata, 0);
        sb_q.delete();
        bus.mem_ack = 1'b1;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        #2 g_resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge g_clk);
            check("post_rst_no_recv", bus.mem_recv, 0);
            check("post_rst_out",     outstanding,  0);
        end
        @(posedge g_clk);
        #1;
        do_req(1'b0, 4'h0, 32'h0, 32'h10, 32'hDEADABEF, 1'b0, w);
        check("post_rst_gnt_wait", w, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
